fc_argmax: RTL

FC_ARGMAX -- requirements
Module: fc_argmax

---
 rtl/fc_argmax.sv | 115 +++++++++++
 1 files changed

// File: rtl/fc_argmax.sv
// Streams NUM_CLASSES signed scores and reports the index/value of the maximum; result/done one cycle after last beat.
// Backpressure: in_ready only in SCAN, in_valid gaps stall without timeout, enable low aborts the frame.
module fc_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [IDX_W-1:0]  result,
  output logic [DATA_W-1:0] max_value,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(NUM_CLASSES + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   wmax_q, wmax_d;
  logic [IDX_W-1:0]    widx_q, widx_d;
  logic [IDX_W-1:0]    result_q, result_d;
  logic [DATA_W-1:0]   maxv_q, maxv_d;

  logic                take_beat;
  logic [DATA_W-1:0]   beat_max;
  logic [IDX_W-1:0]    beat_idx;

  // Working values as they would stand after the current beat; strict '>' keeps the lowest index on ties.
  always_comb begin
    take_beat = (cnt_q == '0) || ($signed(in_data) > $signed(wmax_q));
    beat_max  = wmax_q;
    beat_idx  = widx_q;
    if (take_beat) begin
      beat_max = in_data;
      beat_idx = IDX_W'(cnt_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wmax_d   = wmax_q;
    widx_d   = widx_q;
    result_d = result_q;
    maxv_d   = maxv_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SCAN;
          cnt_d   = '0;
          wmax_d  = '0;
          widx_d  = '0;
        end
      end
      SCAN: begin
        if (!enable) begin
          // Abort drops the partial frame; the beat on this cycle is ignored.
          state_d = IDLE;
          cnt_d   = '0;
          wmax_d  = '0;
          widx_d  = '0;
        end else if (in_valid) begin
          wmax_d = beat_max;
          widx_d = beat_idx;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d  = DONE;
            result_d = beat_idx;
            maxv_d   = beat_max;
          end
        end
      end
      DONE: begin
        if (!enable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wmax_q   <= '0;
      widx_q   <= '0;
      result_q <= '0;
      maxv_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wmax_q   <= wmax_d;
      widx_q   <= widx_d;
      result_q <= result_d;
      maxv_q   <= maxv_d;
    end
  end

  // Status outputs decode straight from state so an async reset clears them immediately.
  assign in_ready  = (state_q == SCAN);
  assign busy      = (state_q == SCAN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign max_value = maxv_q;

endmodule
